// File: rtl/jump_table_pkg.sv
// Shared definitions for the jump-target table: default widths, pointer/target
// typedefs, invalidate FSM states and the clear-counter width helper.
package jump_table_pkg;

    localparam int JT_PTR_W  = 5;
    localparam int JT_ADDR_W = 12;
    localparam int JT_DEPTH  = 32;

    typedef logic [JT_PTR_W-1:0]  jptr_t;
    typedef logic [JT_ADDR_W-1:0] jaddr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } jt_state_e;

    // Clear counter indexes DEPTH entries; a single-entry table still needs one bit.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/jump_table_clr_fsm.sv
// Bulk-invalidate sequencer: walks the clear index from 0 to DEPTH-1, one entry
// per cycle, and blocks writes while walking.
module jump_table_clr_fsm
    import jump_table_pkg::*;
#(
    parameter int DEPTH = JT_DEPTH,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic             wr_ready,
    output logic             clr_en,
    output logic [CNT_W-1:0] clr_idx,
    output jt_state_e        state
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    jt_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // clr_req is deliberately ignored here so the walk never restarts.
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_done = done_q;
    assign wr_ready = (state_q == IDLE);
    assign clr_en   = (state_q == CLEAR);
    assign clr_idx  = cnt_q;
    assign state    = state_q;

endmodule

// File: rtl/jump_table.sv
// Runtime-programmable jump-target table with a registered one-cycle read,
// same-cycle write bypass and a sequenced bulk invalidate.
module jump_table
    import jump_table_pkg::*;
#(
    parameter int PTR_W  = JT_PTR_W,
    parameter int ADDR_W = JT_ADDR_W,
    parameter int DEPTH  = JT_DEPTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  Jptr,
    output logic [ADDR_W-1:0] Jump,
    output logic              hit,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    output logic              wr_ready,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int             CNT_W   = cnt_width(DEPTH);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W + 1)'(DEPTH);

    logic              clr_en;
    logic [CNT_W-1:0]  clr_idx;
    jt_state_e         fsm_state;

    logic [ADDR_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] jump_q, jump_d;
    logic              hit_q, hit_d;

    logic wr_fire;
    logic rd_in_range;

    jump_table_clr_fsm #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_clr_fsm (
        .Clk      (Clk),
        .Reset    (Reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .wr_ready (wr_ready),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx),
        .state    (fsm_state)
    );

    // Out-of-range writes are still accepted (wr_ready high) but change nothing.
    assign wr_fire     = we && wr_ready && ({1'b0, waddr} < DEPTH_P);
    assign rd_in_range = ({1'b0, Jptr} < DEPTH_P);

    always_comb begin
        valid_d = valid_q;
        if (clr_en) valid_d[clr_idx] = 1'b0;
        if (wr_fire) valid_d[waddr] = 1'b1;
    end

    always_comb begin
        jump_d = jump_q;
        hit_d  = hit_q;
        if (rd_en) begin
            if (!rd_in_range) begin
                jump_d = '0;
                hit_d  = 1'b0;
            end else if (wr_fire && (waddr == Jptr)) begin
                jump_d = wdata;
                hit_d  = 1'b1;
            end else if (clr_en && (PTR_W'(clr_idx) == Jptr)) begin
                jump_d = '0;
                hit_d  = 1'b0;
            end else begin
                hit_d  = valid_q[Jptr];
                jump_d = valid_q[Jptr] ? data_mem[Jptr] : '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire) data_mem[waddr] <= wdata;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= '0;
            jump_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            jump_q  <= jump_d;
            hit_q   <= hit_d;
        end
    end

    assign Jump = jump_q;
    assign hit  = hit_q;

endmodule

// File: doc/jump_table.md
Name: jump_table

Overview:
- Runtime-programmable jump-target table; replaces the fixed pointer-to-address decode in the fetch/branch path.
- Branch logic supplies a jump pointer and receives a registered target address plus a hit flag one cycle later.
- The table is written by the loader/control path and has a sequenced bulk-invalidate.

Parameters:
- PTR_W, 5, jump pointer width.
- ADDR_W, 12, jump target (PC) width.
- DEPTH, 32, number of implemented entries. Must satisfy 1 <= DEPTH <= 2**PTR_W. Need not be a power of two.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request.
- Jptr  in  PTR_W  read pointer.
- Jump  out  ADDR_W  registered target. Value is 0 on miss.
- hit  out  1  registered: the pointed entry was valid.
- we  in  1  write request.
- waddr  in  PTR_W  write index.
- wdata  in  ADDR_W  write target.
- wr_ready  out  1  write accepted this cycle when we && wr_ready.
- clr_req  in  1  start a bulk invalidate.
- busy  out  1  invalidate in progress.
- clr_done  out  1  one-cycle pulse when the invalidate completes.

Behaviour:
- Storage:
  - DEPTH x ADDR_W data array, not reset.
  - DEPTH valid bits, cleared by Reset.
- Reset (async assert, sync release): Jump=0, hit=0, busy=0, clr_done=0, state=IDLE, clear counter=0, all valid=0. Reset mid-invalidate aborts it; no clr_done is issued.
- wr_ready is combinational: 1 in IDLE, 0 in CLEAR.
- Write:
  - When we && wr_ready && waddr<DEPTH: data[waddr]<=wdata and valid[waddr]<=1 at the edge.
  - A write with waddr>=DEPTH is accepted and discarded.
  - A write attempted while wr_ready=0 is not performed. The requester holds we until it is accepted.
- Read, latency 1:
  - On an edge with rd_en=1, the outputs update as follows:
    - Jptr>=DEPTH: Jump<=0, hit<=0.
    - Write accepted the same cycle with waddr==Jptr: bypass, so Jump<=wdata, hit<=1.
    - Entry being invalidated the same cycle (CLEAR, counter==Jptr): Jump<=0, hit<=0.
    - Otherwise: hit<=valid[Jptr], and Jump<=data[Jptr] if valid, else 0.
  - With rd_en=0, Jump and hit hold their values.
- Invalidate FSM, states IDLE and CLEAR:
  - IDLE, clr_req=1: go to CLEAR, counter<=0, busy<=1 on the next edge.
  - CLEAR: each cycle valid[counter]<=0 and counter increments.
  - CLEAR, counter==DEPTH-1: clear the last entry, return to IDLE, busy<=0, clr_done<=1 for one cycle.
  - A full invalidate takes exactly DEPTH cycles in CLEAR.
  - clr_req while in CLEAR is ignored; it does not restart the walk.
  - clr_req in the same cycle as a write in IDLE: the write completes, then CLEAR starts next cycle and invalidates that entry too.
  - Reads are allowed throughout CLEAR. Entries not yet reached still hit.
- Counter width is $clog2(DEPTH), minimum 1. The counter never wraps past DEPTH-1.

Decomposition:
- Shared processor package:
  - PTR_W/ADDR_W defaults.
  - Typedefs jptr_t and jaddr_t.
  - Enum jt_state_e {IDLE, CLEAR}.
- One natural sub-module, jump_table_clr_fsm: owns the state, counter, busy, clr_done and wr_ready, and emits a clear strobe plus index to the storage.
- The storage and read logic stay in jump_table.

Test Plan:
- Reset then read Jptr=3 -> next cycle Jump=0, hit=0. Write 3<=0x04D, read 3 -> Jump=0x04D, hit=1 one cycle after rd_en.
- Same-cycle write 7<=0x0AB with read Jptr=7 (previously invalid) -> next cycle Jump=0x0AB, hit=1 (bypass).
- Fill entries 0..31 with idx+100, pulse clr_req:
  - busy=1 for exactly 32 cycles, then clr_done pulses once and busy=0.
  - A read of 31 at CLEAR cycle 5 hits with 131.
  - A read of 31 after clr_done misses.
  - we held during CLEAR sees wr_ready=0 and completes on the first IDLE cycle.
- DEPTH=17: write 20<=0x123, then read 20 -> Jump=0, hit=0. Read 16 after writing 16<=0x0AD -> hit with 0x0AD.
- Assert Reset at CLEAR cycle 10 -> busy=0 immediately, no clr_done, all entries miss, and a new clr_req restarts from counter 0.
- rd_en=0 for 3 cycles after a hit on 0x04D while entry 3 is rewritten to 0x055 -> Jump holds 0x04D until the next rd_en.
